ct_rtu_ereg_fflags_acc: RTL and testbench
=========================================

Name: ct_rtu_ereg_fflags_acc

Overview:
Retire-side consumer of the physical extension-register (ereg) file. Each retiring ereg entry presents a 6-bit accumulate value. This block ORs those values into a sticky architectural flag register and pushes changes to CP0 over a valid/ack handshake. It sits between the RTU retire slots and the CP0 fcsr/vxsat logic, and also handles CSR overwrites from CP0.

Parameters:
RETIRE_W, 3, number of retire slots per cycle
FLAG_W, 6, flag width; [4:0]=NV/DZ/OF/UF/NX, [5]=vxsat

Ports:
forever_cpuclk  in  1  sole clock
cpurst  in  1  reset; synchronous, active-high
rtu_ereg_retire_vld  in  RETIRE_W  per-slot retire valid
rtu_ereg_retire0_data  in  FLAG_W  slot 0 accumulate value (already gated by retired/released)
rtu_ereg_retire1_data  in  FLAG_W  slot 1 accumulate value
rtu_ereg_retire2_data  in  FLAG_W  slot 2 accumulate value
cp0_ereg_fflags_wen  in  1  CSR write to fflags/vxsat
cp0_ereg_fflags_wdata  in  FLAG_W  CSR write data
cp0_ereg_upd_ack  in  1  CP0 accepted the update
ereg_cp0_upd_vld  out  1  update request
ereg_cp0_upd_data  out  FLAG_W  new full sticky value
ereg_cp0_acc_value  out  FLAG_W  current sticky value
ereg_top_idle  out  1  nothing in flight; upstream uses it for clock gating

Behaviour:
- Reset (cpurst=1 at a forever_cpuclk edge):
  - s1_vld=0, s1_data=0, pend=0, sticky=0, state=IDLE.
  - Outputs: upd_vld=0, upd_data=0, acc_value=0, idle=1.
  - A reset mid-handshake drops upd_vld the next cycle with no ack required.
- Stage S1 (1 cycle):
  - s1_vld <= |retire_vld.
  - s1_data <= OR of the data of valid slots only; invalid-slot data is ignored even if nonzero.
- Stage S2: when s1_vld, pend <= pend | s1_data. Retire-to-pend latency is 2 cycles.
- sticky only ever changes on ack or on a CP0 write. acc_value = sticky, registered.
- FSM, two states:
  - IDLE: if (pend & ~sticky)!=0, go to REQ. Latch upd_data <= sticky|pend and set upd_vld=1 the next cycle. Otherwise stay. A pend that adds no new bits never raises a request.
  - REQ: upd_vld=1 and upd_data held stable until ack.
    - Bits arriving in pend during REQ do not alter upd_data.
    - On ack: sticky <= upd_data, pend <= pend & ~upd_data, go to IDLE.
    - upd_vld is low for at least one cycle after each ack. The FSM re-evaluates in IDLE and issues a second request only if new bits remain.
- Ack while in IDLE is ignored.
- CP0 write (highest priority):
  - sticky <= wdata; pend <= 0; s1_vld/s1_data cleared. In-flight retire data is older than the CSR write and is discarded.
  - Retire inputs presented in the same cycle as wen are younger and are captured into S1 normally.
  - If in REQ: upd_vld drops next cycle and state goes to IDLE. An ack in the same cycle as wen is ignored, so sticky = wdata.
- Width rules: all flag logic is pure bitwise OR/AND-NOT. No arithmetic, no wrap.
- idle = !s1_vld && pend==0 && state==IDLE, registered output.

Test Plan:
- Reset, then slot0 vld with data 6'h01 -> 2 cycles later pend=01; next cycle upd_vld=1, upd_data=01; ack -> acc_value=01, upd_vld=0, idle=1.
- Same cycle: slot0=6'h04, slot1 invalid with data 6'h3F, slot2=6'h10 -> upd_data=6'h14; slot1 data must not appear.
- sticky=6'h14, then retire 6'h04 -> no request; pend clears; idle returns 1 with no upd_vld.
- During REQ (upd_data=01), retire 6'h20 and hold ack off 5 cycles -> upd_data stays 01 throughout. After ack, one upd_vld-low cycle, then a request with upd_data=6'h21.
- During REQ, assert wen with wdata=6'h00 together with ack -> acc_value=00, upd_vld=0 next cycle, pend=0, no further request.
- Assert cpurst while upd_vld=1 with pend=6'h08 -> the next cycle has all outputs at reset values and idle=1.

Source files
------------

// File: rtl/ct_rtu_ereg_fflags_acc.sv
// ct_rtu_ereg_fflags_acc
//   Accumulates the per-entry floating-point / vxsat flag values of retiring
//   ereg entries into a sticky architectural flag register. Any bit that is
//   new to that register is pushed to CP0 over a valid/ack handshake. CP0 can
//   also overwrite the register directly with a CSR write.
//
// Ports
//   forever_cpuclk         clock
//   cpurst                 synchronous active-high reset
//   rtu_ereg_retire_vld    per-slot retire valid
//   rtu_ereg_retireN_data  per-slot accumulate value (slots 0..2)
//   cp0_ereg_fflags_wen    CSR write to fflags/vxsat
//   cp0_ereg_fflags_wdata  CSR write data
//   cp0_ereg_upd_ack       CP0 accepted the pending update
//   ereg_cp0_upd_vld       update request to CP0
//   ereg_cp0_upd_data      full new sticky value offered to CP0
//   ereg_cp0_acc_value     current sticky value
//   ereg_top_idle          nothing in flight (used upstream for clock gating)
module ct_rtu_ereg_fflags_acc #(
  parameter int RETIRE_W = 3,
  parameter int FLAG_W   = 6
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic [RETIRE_W-1:0] rtu_ereg_retire_vld,
  input  logic [FLAG_W-1:0]   rtu_ereg_retire0_data,
  input  logic [FLAG_W-1:0]   rtu_ereg_retire1_data,
  input  logic [FLAG_W-1:0]   rtu_ereg_retire2_data,
  input  logic                cp0_ereg_fflags_wen,
  input  logic [FLAG_W-1:0]   cp0_ereg_fflags_wdata,
  input  logic                cp0_ereg_upd_ack,
  output logic                ereg_cp0_upd_vld,
  output logic [FLAG_W-1:0]   ereg_cp0_upd_data,
  output logic [FLAG_W-1:0]   ereg_cp0_acc_value,
  output logic                ereg_top_idle
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t            state, state_nxt;

  logic              vld_p1, vld_p1_nxt;
  logic [FLAG_W-1:0] data_p1, data_p1_nxt;
  logic [FLAG_W-1:0] pend_p2, pend_p2_nxt;
  logic [FLAG_W-1:0] sticky, sticky_nxt;
  logic [FLAG_W-1:0] upd_data, upd_data_nxt;
  logic              upd_vld_nxt;
  logic              idle, idle_nxt;
  logic [FLAG_W-1:0] clr_mask;
  logic [FLAG_W-1:0] retire_or;

  // Only valid slots contribute; invalid-slot data may be stale garbage.
  always_comb begin
    retire_or = ({FLAG_W{rtu_ereg_retire_vld[0]}} & rtu_ereg_retire0_data)
              | ({FLAG_W{rtu_ereg_retire_vld[1]}} & rtu_ereg_retire1_data)
              | ({FLAG_W{rtu_ereg_retire_vld[2]}} & rtu_ereg_retire2_data);
  end

  always_comb begin
    // ---- stage S1: merge retire slots ----
    vld_p1_nxt   = |rtu_ereg_retire_vld;
    data_p1_nxt  = retire_or;

    state_nxt    = state;
    sticky_nxt   = sticky;
    upd_data_nxt = upd_data;
    clr_mask     = '0;

    case (state)
      IDLE: begin
        // Pend bits already present in sticky carry no news; drop them so
        // the block can go idle without bothering CP0.
        clr_mask = sticky;
        if ((pend_p2 & ~sticky) != '0) begin
          state_nxt    = REQ;
          upd_data_nxt = sticky | pend_p2;
        end
      end
      REQ: begin
        // upd_data stays frozen until CP0 accepts it; later arrivals wait
        // in pend for the next request.
        if (cp0_ereg_upd_ack) begin
          sticky_nxt = upd_data;
          clr_mask   = upd_data;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // ---- stage S2: accumulate into pend ----
    pend_p2_nxt = (pend_p2 & ~clr_mask) | (vld_p1 ? data_p1 : '0);

    // A CSR write is newer than anything already in S1/S2 and wins over a
    // coincident ack. Retires presented this cycle are younger and still
    // enter S1 above.
    if (cp0_ereg_fflags_wen) begin
      sticky_nxt  = cp0_ereg_fflags_wdata;
      pend_p2_nxt = '0;
      state_nxt   = IDLE;
    end

    upd_vld_nxt = (state_nxt == REQ);
    idle_nxt    = !vld_p1_nxt && (pend_p2_nxt == '0) && (state_nxt == IDLE);
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state            <= IDLE;
      vld_p1           <= 1'b0;
      data_p1          <= '0;
      pend_p2          <= '0;
      sticky           <= '0;
      upd_data         <= '0;
      ereg_cp0_upd_vld <= 1'b0;
      idle             <= 1'b1;
    end else begin
      state            <= state_nxt;
      vld_p1           <= vld_p1_nxt;
      data_p1          <= data_p1_nxt;
      pend_p2          <= pend_p2_nxt;
      sticky           <= sticky_nxt;
      upd_data         <= upd_data_nxt;
      ereg_cp0_upd_vld <= upd_vld_nxt;
      idle             <= idle_nxt;
    end
  end

  assign ereg_cp0_upd_data  = upd_data;
  assign ereg_cp0_acc_value = sticky;
  assign ereg_top_idle      = idle;

endmodule

// File: tb/tb_ct_rtu_ereg_fflags_acc.sv
// Directed bench for ct_rtu_ereg_fflags_acc: a table of single-retire
// transactions plus hand-written multi-cycle handshake sequences.
module tb_ct_rtu_ereg_fflags_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] vld;
  logic [5:0] d0, d1, d2;
  logic       wen;
  logic [5:0] wdata;
  logic       ack;
  logic       upd_vld;
  logic [5:0] upd_data;
  logic [5:0] acc;
  logic       idle;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ct_rtu_ereg_fflags_acc #(.RETIRE_W(3), .FLAG_W(6)) dut (
    .forever_cpuclk        (clk),
    .cpurst                (rst),
    .rtu_ereg_retire_vld   (vld),
    .rtu_ereg_retire0_data (d0),
    .rtu_ereg_retire1_data (d1),
    .rtu_ereg_retire2_data (d2),
    .cp0_ereg_fflags_wen   (wen),
    .cp0_ereg_fflags_wdata (wdata),
    .cp0_ereg_upd_ack      (ack),
    .ereg_cp0_upd_vld      (upd_vld),
    .ereg_cp0_upd_data     (upd_data),
    .ereg_cp0_acc_value    (acc),
    .ereg_top_idle         (idle)
  );

  typedef struct {
    logic [5:0] init;
    logic [2:0] vld;
    logic [5:0] d0;
    logic [5:0] d1;
    logic [5:0] d2;
    logic       req;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic csr_write(input logic [5:0] v);
    wen = 1'b1; wdata = v;
    step();
    wen = 1'b0; wdata = '0;
  endtask

  task automatic retire(input logic [2:0] v, input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    vld = v; d0 = a; d1 = b; d2 = c;
  endtask

  task automatic retire_clr();
    vld = '0; d0 = '0; d1 = '0; d2 = '0;
  endtask

  // Bring up a request carrying 6'h01 from a clean sticky of 0.
  task automatic enter_req01();
    csr_write(6'h00);
    retire(3'b001, 6'h01, 6'h00, 6'h00);
    step();
    retire_clr();
    step();
    step();
    chk("req01_vld", {7'd0, upd_vld}, 8'h01);
    chk("req01_data", {2'd0, upd_data}, 8'h01);
  endtask

  initial begin
    rst = 1'b1; vld = '0; d0 = '0; d1 = '0; d2 = '0;
    wen = 1'b0; wdata = '0; ack = 1'b0;

    vecs[0] = '{init: 6'h00, vld: 3'b001, d0: 6'h01, d1: 6'h00, d2: 6'h00, req: 1'b1, exp: 6'h01};
    vecs[1] = '{init: 6'h00, vld: 3'b101, d0: 6'h04, d1: 6'h3F, d2: 6'h10, req: 1'b1, exp: 6'h14};
    vecs[2] = '{init: 6'h14, vld: 3'b001, d0: 6'h04, d1: 6'h00, d2: 6'h00, req: 1'b0, exp: 6'h00};
    vecs[3] = '{init: 6'h00, vld: 3'b000, d0: 6'h3F, d1: 6'h3F, d2: 6'h3F, req: 1'b0, exp: 6'h00};
    vecs[4] = '{init: 6'h01, vld: 3'b111, d0: 6'h02, d1: 6'h04, d2: 6'h20, req: 1'b1, exp: 6'h27};
    vecs[5] = '{init: 6'h3F, vld: 3'b111, d0: 6'h3F, d1: 6'h01, d2: 6'h20, req: 1'b0, exp: 6'h00};
    vecs[6] = '{init: 6'h0A, vld: 3'b010, d0: 6'h30, d1: 6'h0F, d2: 6'h00, req: 1'b1, exp: 6'h0F};

    step();
    step();
    chk("rst_upd_vld", {7'd0, upd_vld}, 8'h00);
    chk("rst_upd_data", {2'd0, upd_data}, 8'h00);
    chk("rst_acc", {2'd0, acc}, 8'h00);
    chk("rst_idle", {7'd0, idle}, 8'h01);
    rst = 1'b0;
    step();

    // Table: preset sticky, retire once, expect a request (or none), ack.
    for (int i = 0; i < 7; i++) begin
      csr_write(vecs[i].init);
      chk($sformatf("v%0d_init_acc", i), {2'd0, acc}, {2'd0, vecs[i].init});
      retire(vecs[i].vld, vecs[i].d0, vecs[i].d1, vecs[i].d2);
      step();
      retire_clr();
      step();
      step();
      chk($sformatf("v%0d_upd_vld", i), {7'd0, upd_vld}, {7'd0, vecs[i].req});
      if (vecs[i].req)
        chk($sformatf("v%0d_upd_data", i), {2'd0, upd_data}, {2'd0, vecs[i].exp});
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk($sformatf("v%0d_acc", i), {2'd0, acc},
          {2'd0, (vecs[i].req ? vecs[i].exp : vecs[i].init)});
      chk($sformatf("v%0d_vld_low", i), {7'd0, upd_vld}, 8'h00);
      chk($sformatf("v%0d_idle", i), {7'd0, idle}, 8'h01);
    end

    // Late bits during REQ must not disturb upd_data; they cause a second
    // request only after a one-cycle gap.
    enter_req01();
    retire(3'b001, 6'h20, 6'h00, 6'h00);
    for (int k = 0; k < 5; k++) begin
      step();
      retire_clr();
      chk($sformatf("hold%0d_vld", k), {7'd0, upd_vld}, 8'h01);
      chk($sformatf("hold%0d_data", k), {2'd0, upd_data}, 8'h01);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("gap_vld", {7'd0, upd_vld}, 8'h00);
    chk("gap_acc", {2'd0, acc}, 8'h01);
    step();
    chk("second_vld", {7'd0, upd_vld}, 8'h01);
    chk("second_data", {2'd0, upd_data}, 8'h21);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("second_acc", {2'd0, acc}, 8'h21);
    chk("second_idle", {7'd0, idle}, 8'h01);

    // CSR write coinciding with ack during REQ: write wins, pend discarded.
    enter_req01();
    retire(3'b001, 6'h08, 6'h00, 6'h00);
    step();
    retire_clr();
    step();
    wen = 1'b1; wdata = 6'h00; ack = 1'b1;
    step();
    wen = 1'b0; ack = 1'b0;
    chk("wen_ack_acc", {2'd0, acc}, 8'h00);
    chk("wen_ack_vld", {7'd0, upd_vld}, 8'h00);
    chk("wen_ack_idle", {7'd0, idle}, 8'h01);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("wen_quiet%0d", k), {7'd0, upd_vld}, 8'h00);
    end

    // Retire in the same cycle as a CSR write is younger and survives.
    wen = 1'b1; wdata = 6'h00;
    retire(3'b001, 6'h02, 6'h00, 6'h00);
    step();
    wen = 1'b0;
    retire_clr();
    step();
    step();
    chk("wen_young_vld", {7'd0, upd_vld}, 8'h01);
    chk("wen_young_data", {2'd0, upd_data}, 8'h02);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("wen_young_acc", {2'd0, acc}, 8'h02);

    // Reset mid-handshake with bits still pending.
    enter_req01();
    retire(3'b001, 6'h08, 6'h00, 6'h00);
    step();
    retire_clr();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_vld", {7'd0, upd_vld}, 8'h00);
    chk("mid_rst_data", {2'd0, upd_data}, 8'h00);
    chk("mid_rst_acc", {2'd0, acc}, 8'h00);
    chk("mid_rst_idle", {7'd0, idle}, 8'h01);
    rst = 1'b0;
    step();
    step();
    chk("post_rst_vld", {7'd0, upd_vld}, 8'h00);
    chk("post_rst_idle", {7'd0, idle}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
